// File: rtl/fpu_seq.sv
// fpu_seq: multicycle sequencer for the shared single-precision FPU datapath.
// A start pulse with an opcode walks the datapath through load, align,
// add/mul, normalize, round and writeback, one strobe per cycle.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start, op[1:0]      request and opcode (00 add, 01 sub, 10 mul, 11 illegal)
//   exp_diff[7:0]       |expA-expB|, valid in PREP
//   swap_req            operand B has larger magnitude, valid in PREP
//   mant_ovf            mantissa carry-out, valid in NCHK
//   lead_zeros[4:0]     leading-zero count, valid in NCHK (31 = zero mantissa)
//   busy                sequencer is not idle
//   ld_ops .. round_en  per-cycle datapath strobes
//   fpu_we, illegal     writeback qualifiers
//   done                one-cycle completion pulse
module fpu_seq #(
    parameter int unsigned MUL_CYCLES = 24,
    parameter int unsigned ALIGN_MAX  = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] exp_diff,
    input  logic       swap_req,
    input  logic       mant_ovf,
    input  logic [4:0] lead_zeros,
    output logic       busy,
    output logic       ld_ops,
    output logic       swap,
    output logic       flush,
    output logic       shift_r_en,
    output logic       add_en,
    output logic       sub_mode,
    output logic       mul_en,
    output logic       norm_r_en,
    output logic       norm_l_en,
    output logic       zero_res,
    output logic       round_en,
    output logic       fpu_we,
    output logic       illegal,
    output logic       done
);

    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] MUL_LOAD  = CW'(MUL_CYCLES - 1);
    localparam logic [7:0]    ALIGN_LIM = 8'(ALIGN_MAX);
    localparam logic [4:0]    LZ_ZERO   = 5'd31;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_PREP,
        S_ALIGN,
        S_ADD,
        S_MUL,
        S_NCHK,
        S_NORM,
        S_ROUND,
        S_WB
    } state_t;

    state_t         state;
    logic [1:0]     op_q;
    logic [CW-1:0]  cnt;

    // State, captured opcode and shared down-counter (align / mul / normalize)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= 2'b00;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (op_q == OP_ILL) begin
                        state <= S_WB;
                    end else if (op_q == OP_MUL) begin
                        cnt   <= MUL_LOAD;
                        state <= S_MUL;
                    end else begin
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    // Zero difference needs no shift; huge difference flushes
                    if (exp_diff == 8'd0 || exp_diff >= ALIGN_LIM) begin
                        state <= S_ADD;
                    end else begin
                        cnt   <= CW'(exp_diff - 8'd1);
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (cnt == '0) state <= S_ADD;
                    else           cnt   <= cnt - CW'(1);
                end
                S_ADD: state <= S_NCHK;
                S_MUL: begin
                    if (cnt == '0) state <= S_NCHK;
                    else           cnt   <= cnt - CW'(1);
                end
                S_NCHK: begin
                    if (mant_ovf || lead_zeros == LZ_ZERO || lead_zeros == 5'd0) begin
                        state <= S_ROUND;
                    end else begin
                        cnt   <= CW'(lead_zeros - 5'd1);
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (cnt == '0) state <= S_ROUND;
                    else           cnt   <= cnt - CW'(1);
                end
                S_ROUND: state <= S_WB;
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decodes of the current state so a reset clears them at once
    assign busy       = (state != S_IDLE);
    assign ld_ops     = (state == S_LOAD);
    assign swap       = (state == S_PREP) && swap_req;
    assign flush      = (state == S_PREP) && (exp_diff >= ALIGN_LIM);
    assign shift_r_en = (state == S_ALIGN);
    assign add_en     = (state == S_ADD);
    assign sub_mode   = busy && (op_q == OP_SUB);
    assign mul_en     = (state == S_MUL);
    assign norm_r_en  = (state == S_NCHK) && mant_ovf;
    assign zero_res   = (state == S_NCHK) && !mant_ovf && (lead_zeros == LZ_ZERO);
    assign norm_l_en  = (state == S_NORM);
    assign round_en   = (state == S_ROUND);
    assign done       = (state == S_WB);
    assign fpu_we     = (state == S_WB) && (op_q != OP_ILL);
    assign illegal    = (state == S_WB) && (op_q == OP_ILL);

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: table of hand-derived latency/strobe-count vectors, a reset
// abort sequence, and randomized operations checked cycle by cycle against a
// schedule built from the sequencing rules.
module tb_fpu_seq;

    localparam int          MULC   = 24;
    localparam logic [7:0]  ALIGNM = 8'd26;
    localparam int          NVEC   = 11;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op_in;
    logic [7:0] exp_diff;
    logic       swap_req;
    logic       mant_ovf;
    logic [4:0] lead_zeros;
    logic busy, ld_ops, swap, flush, shift_r_en, add_en, sub_mode, mul_en;
    logic norm_r_en, norm_l_en, zero_res, round_en, fpu_we, illegal, done;

    fpu_seq #(.MUL_CYCLES(24), .ALIGN_MAX(26)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op_in),
        .exp_diff(exp_diff), .swap_req(swap_req), .mant_ovf(mant_ovf),
        .lead_zeros(lead_zeros), .busy(busy), .ld_ops(ld_ops), .swap(swap),
        .flush(flush), .shift_r_en(shift_r_en), .add_en(add_en),
        .sub_mode(sub_mode), .mul_en(mul_en), .norm_r_en(norm_r_en),
        .norm_l_en(norm_l_en), .zero_res(zero_res), .round_en(round_en),
        .fpu_we(fpu_we), .illegal(illegal), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic busy, ld_ops, swap, flush, shift_r_en, add_en, sub_mode, mul_en;
        logic norm_r_en, norm_l_en, zero_res, round_en, fpu_we, illegal, done;
    } outs_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] ed;
        logic       sw;
        logic       ovf;
        logic [4:0] lz;
        int done_cyc, add_cyc, round_cyc, n_shift, n_mul, n_norml;
        int n_normr, n_zero, n_flush, n_swap, n_we, n_ill;
    } vec_t;

    typedef struct {
        outs_t      o;
        logic [7:0] ed;
        logic       sw;
        logic       ovf;
        logic [4:0] lz;
    } entry_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl [NVEC];

    function automatic outs_t sample();
        return {busy, ld_ops, swap, flush, shift_r_en, add_en, sub_mode, mul_en,
                norm_r_en, norm_l_en, zero_res, round_en, fpu_we, illegal, done};
    endfunction

    task automatic check_outs(input string name, input int cyc, input outs_t exp);
        outs_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc %0d: outputs got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Hold start and inputs through the whole op; count strobes until done
    task automatic run_vec(input int idx, input vec_t v);
        int cyc, done_c, add_c, rnd_c, ns, nm, nl, nr, nz, nf, nsw, nwe, nill, nld;
        bit got;
        cyc = 0; done_c = 0; add_c = 0; rnd_c = 0; ns = 0; nm = 0; nl = 0; nr = 0;
        nz = 0; nf = 0; nsw = 0; nwe = 0; nill = 0; nld = 0; got = 0;
        start = 1'b1; op_in = v.op; exp_diff = v.ed; swap_req = v.sw;
        mant_ovf = v.ovf; lead_zeros = v.lz;
        @(posedge clk); #1;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (add_en && add_c == 0)   add_c = cyc;
            if (round_en && rnd_c == 0) rnd_c = cyc;
            ns += int'(shift_r_en); nm += int'(mul_en); nl += int'(norm_l_en);
            nr += int'(norm_r_en); nz += int'(zero_res); nf += int'(flush);
            nsw += int'(swap); nwe += int'(fpu_we); nill += int'(illegal);
            nld += int'(ld_ops);
            if (done) begin
                got = 1; done_c = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        check_int($sformatf("v%0d done_cyc", idx), done_c, v.done_cyc);
        check_int($sformatf("v%0d add_cyc", idx), add_c, v.add_cyc);
        check_int($sformatf("v%0d round_cyc", idx), rnd_c, v.round_cyc);
        check_int($sformatf("v%0d shifts", idx), ns, v.n_shift);
        check_int($sformatf("v%0d muls", idx), nm, v.n_mul);
        check_int($sformatf("v%0d norm_l", idx), nl, v.n_norml);
        check_int($sformatf("v%0d norm_r", idx), nr, v.n_normr);
        check_int($sformatf("v%0d zero_res", idx), nz, v.n_zero);
        check_int($sformatf("v%0d flush", idx), nf, v.n_flush);
        check_int($sformatf("v%0d swap", idx), nsw, v.n_swap);
        check_int($sformatf("v%0d fpu_we", idx), nwe, v.n_we);
        check_int($sformatf("v%0d illegal", idx), nill, v.n_ill);
        check_int($sformatf("v%0d ld_ops", idx), nld, 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_outs($sformatf("v%0d idle_after", idx), 0, '0);
        @(posedge clk); #1;
    endtask

    function automatic entry_t fresh(input logic [1:0] op);
        entry_t e;
        e.ed  = 8'($urandom);
        e.sw  = 1'($urandom);
        e.ovf = 1'($urandom);
        e.lz  = 5'($urandom);
        e.o   = '0;
        e.o.busy     = 1'b1;
        e.o.sub_mode = (op == 2'b01);
        return e;
    endfunction

    // Build the expected per-cycle schedule, then replay it with noise on
    // every input that is not meaningful in that cycle
    task automatic run_rand(input int k, input logic [1:0] op, input logic [7:0] ed,
                            input logic sw, input logic ovf, input logic [4:0] lz);
        entry_t q[$];
        entry_t e;
        int a, z, cyc;
        e = fresh(op); e.o.ld_ops = 1'b1; q.push_back(e);
        if (op == 2'b11) begin
            e = fresh(op); e.o.done = 1'b1; e.o.illegal = 1'b1; q.push_back(e);
        end else begin
            if (op == 2'b10) begin
                for (int i = 0; i < MULC; i++) begin
                    e = fresh(op); e.o.mul_en = 1'b1; q.push_back(e);
                end
            end else begin
                e = fresh(op); e.ed = ed; e.sw = sw;
                e.o.swap = sw; e.o.flush = (ed >= ALIGNM); q.push_back(e);
                a = (ed >= ALIGNM) ? 0 : int'(ed);
                for (int i = 0; i < a; i++) begin
                    e = fresh(op); e.o.shift_r_en = 1'b1; q.push_back(e);
                end
                e = fresh(op); e.o.add_en = 1'b1; q.push_back(e);
            end
            e = fresh(op); e.ovf = ovf; e.lz = lz;
            e.o.norm_r_en = ovf; e.o.zero_res = !ovf && (lz == 5'd31); q.push_back(e);
            z = (ovf || lz == 5'd31) ? 0 : int'(lz);
            for (int i = 0; i < z; i++) begin
                e = fresh(op); e.o.norm_l_en = 1'b1; q.push_back(e);
            end
            e = fresh(op); e.o.round_en = 1'b1; q.push_back(e);
            e = fresh(op); e.o.done = 1'b1; e.o.fpu_we = 1'b1; q.push_back(e);
        end
        start = 1'b1; op_in = op;
        exp_diff = 8'($urandom); swap_req = 1'($urandom);
        mant_ovf = 1'($urandom); lead_zeros = 5'($urandom);
        @(negedge clk);
        check_outs($sformatf("r%0d idle", k), 0, '0);
        @(posedge clk); #1;
        cyc = 0;
        foreach (q[i]) begin
            cyc++;
            start = 1'($urandom); op_in = 2'($urandom);
            exp_diff = q[i].ed; swap_req = q[i].sw;
            mant_ovf = q[i].ovf; lead_zeros = q[i].lz;
            @(negedge clk);
            check_outs($sformatf("r%0d op%0d", k, op), cyc, q[i].o);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        // op, ed, sw, ovf, lz, done, add, round, shift, mul, norml, normr, zero, flush, swap, we, ill
        tbl[0]  = '{2'b00, 8'd3,  1'b1, 1'b0, 5'd0,  9,  6,  8,  3, 0,  0, 0, 0, 0, 1, 1, 0};
        tbl[1]  = '{2'b10, 8'd0,  1'b0, 1'b1, 5'd0,  28, 0,  27, 0, 24, 0, 1, 0, 0, 0, 1, 0};
        tbl[2]  = '{2'b01, 8'd0,  1'b0, 1'b0, 5'd5,  11, 3,  10, 0, 0,  5, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{2'b00, 8'd40, 1'b0, 1'b0, 5'd31, 6,  3,  5,  0, 0,  0, 0, 1, 1, 0, 1, 0};
        tbl[4]  = '{2'b11, 8'd5,  1'b1, 1'b1, 5'd3,  2,  0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{2'b00, 8'd25, 1'b0, 1'b0, 5'd0,  31, 28, 30, 25, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[6]  = '{2'b00, 8'd26, 1'b1, 1'b0, 5'd0,  6,  3,  5,  0, 0,  0, 0, 0, 1, 1, 1, 0};
        tbl[7]  = '{2'b01, 8'd1,  1'b0, 1'b0, 5'd1,  8,  4,  7,  1, 0,  1, 0, 0, 0, 0, 1, 0};
        tbl[8]  = '{2'b10, 8'd0,  1'b0, 1'b0, 5'd3,  31, 0,  30, 0, 24, 3, 0, 0, 0, 0, 1, 0};
        tbl[9]  = '{2'b10, 8'd0,  1'b0, 1'b0, 5'd31, 28, 0,  27, 0, 24, 0, 0, 1, 0, 0, 1, 0};
        tbl[10] = '{2'b00, 8'd2,  1'b0, 1'b1, 5'd31, 8,  5,  7,  2, 0,  0, 1, 0, 0, 0, 1, 0};

        reset = 1'b0; start = 1'b0; op_in = 2'b00; exp_diff = 8'd0;
        swap_req = 1'b0; mant_ovf = 1'b0; lead_zeros = 5'd0;
        #1 reset = 1'b1;
        start = 1'b1;
        #1 check_outs("reset_async", 0, '0);
        @(negedge clk);
        check_outs("reset_held", 0, '0);
        #2 reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_outs("idle_after_reset", 0, '0);
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) run_vec(i, tbl[i]);

        // Reset in the middle of an alignment aborts with no completion
        start = 1'b1; op_in = 2'b00; exp_diff = 8'd3; swap_req = 1'b1;
        mant_ovf = 1'b0; lead_zeros = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        begin
            outs_t ex;
            ex = '0; ex.busy = 1'b1; ex.shift_r_en = 1'b1;
            check_outs("t6 in_align", 4, ex);
        end
        #1 reset = 1'b1;
        #1 check_outs("t6 abort", 0, '0);
        repeat (2) begin
            @(negedge clk);
            check_outs("t6 held", 0, '0);
        end
        #1 reset = 1'b0;
        @(posedge clk); #1;
        run_vec(100, tbl[0]);

        for (int k = 0; k < 250; k++) begin
            logic [1:0] rop;
            logic [7:0] red;
            logic [4:0] rlz;
            int mode;
            rop  = 2'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       red = 8'd0;
                1:       red = 8'($urandom_range(1, 25));
                2:       red = 8'($urandom_range(26, 255));
                default: red = 8'($urandom_range(24, 27));
            endcase
            rlz = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
            repeat ($urandom_range(0, 2)) begin
                start = 1'b0; op_in = 2'($urandom);
                @(negedge clk);
                check_outs($sformatf("r%0d gap", k), 0, '0);
                @(posedge clk); #1;
            end
            run_rand(k, rop, red, 1'($urandom), 1'($urandom), rlz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
